// File: rtl/msp430_ram_dp.sv
// Dual-port synchronous RAM model with per-byte write enables, a configurable
// read-latency pipeline, port-A-wins collision merging and sticky range errors.
module msp430_ram_dp #(
    parameter int ADDR_MSB   = 7,
    parameter int MEM_SIZE   = 256,
    parameter int DATA_WIDTH = 16,
    parameter int RD_LATENCY = 1
) (
    input  logic                      ram_clk,
    input  logic                      ram_rst,
    input  logic                      ram_cen_a,
    input  logic [ADDR_MSB:0]         ram_addr_a,
    input  logic [DATA_WIDTH/8-1:0]   ram_wen_a,
    input  logic [DATA_WIDTH-1:0]     ram_din_a,
    output logic [DATA_WIDTH-1:0]     ram_dout_a,
    output logic                      ram_vld_a,
    output logic                      ram_err_a,
    input  logic                      ram_cen_b,
    input  logic [ADDR_MSB:0]         ram_addr_b,
    input  logic [DATA_WIDTH/8-1:0]   ram_wen_b,
    input  logic [DATA_WIDTH-1:0]     ram_din_b,
    output logic [DATA_WIDTH-1:0]     ram_dout_b,
    output logic                      ram_vld_b,
    output logic                      ram_err_b
);

    localparam int NB_BYTES = DATA_WIDTH / 8;
    localparam int WORDS    = MEM_SIZE / NB_BYTES;
    localparam int AW       = (WORDS > 1) ? $clog2(WORDS) : 1;

    typedef struct packed {
        logic                  vld;
        logic                  err;
        logic [DATA_WIDTH-1:0] data;
    } entry_t;

    logic [DATA_WIDTH-1:0] mem_q [0:WORDS-1];

    logic                  acc  [2];
    logic                  ok   [2];
    logic                  wr   [2];
    logic [AW-1:0]         idx  [2];
    logic [DATA_WIDTH-1:0] word [2];
    logic                  same_addr;

    // word[p] is the final content of port p's address after this edge,
    // including the other port's lanes when both hit the same word.
    // NOTE: combinational blocks use blocking '=' and assign every output a
    // default before any conditional override, so no latch can be inferred.
    always_comb begin
        acc[0]    = ~ram_cen_a;
        acc[1]    = ~ram_cen_b;
        ok[0]     = acc[0] && (32'(ram_addr_a) < 32'(WORDS));
        ok[1]     = acc[1] && (32'(ram_addr_b) < 32'(WORDS));
        idx[0]    = AW'(ram_addr_a);
        idx[1]    = AW'(ram_addr_b);
        same_addr = ok[0] && ok[1] && (idx[0] == idx[1]);
        word[0]   = mem_q[idx[0]];
        word[1]   = mem_q[idx[1]];
        for (int i = 0; i < NB_BYTES; i++) begin
            if (same_addr && !ram_wen_b[i]) word[0][8*i +: 8] = ram_din_b[8*i +: 8];
            if (!ram_wen_a[i])              word[0][8*i +: 8] = ram_din_a[8*i +: 8];
            if (!ram_wen_b[i])              word[1][8*i +: 8] = ram_din_b[8*i +: 8];
        end
        if (same_addr) word[1] = word[0];
        wr[0] = ok[0] && !(&ram_wen_a);
        wr[1] = ok[1] && !(&ram_wen_b);
    end

    // NOTE: the storage array has no reset; contents start undefined (or are
    // preloaded by the bench), only the control pipeline is reset.
    always_ff @(posedge ram_clk) begin
        if (wr[1]) mem_q[idx[1]] <= word[1];
        if (wr[0]) mem_q[idx[0]] <= word[0];
    end

    for (genvar p = 0; p < 2; p++) begin : g_port
        entry_t                issue_d;
        entry_t                last_d;
        logic [DATA_WIDTH-1:0] dout_q;
        logic                  vld_q;
        logic                  err_q;

        always_comb begin
            issue_d.vld  = acc[p];
            issue_d.err  = acc[p] & ~ok[p];
            issue_d.data = ok[p] ? word[p] : '0;
        end

        if (RD_LATENCY > 1) begin : g_pipe
            entry_t pipe_q [RD_LATENCY-1];

            always_ff @(posedge ram_clk or posedge ram_rst) begin
                if (ram_rst) begin
                    pipe_q <= '{default: '0};
                end else begin
                    pipe_q[0] <= issue_d;
                    for (int s = 1; s < RD_LATENCY-1; s++) pipe_q[s] <= pipe_q[s-1];
                end
            end

            assign last_d = pipe_q[RD_LATENCY-2];
        end else begin : g_direct
            assign last_d = issue_d;
        end

        // Output stage: data holds between valid entries, error is sticky.
        always_ff @(posedge ram_clk or posedge ram_rst) begin
            if (ram_rst) begin
                dout_q <= '0;
                vld_q  <= 1'b0;
                err_q  <= 1'b0;
            end else begin
                vld_q <= last_d.vld;
                err_q <= err_q | (last_d.vld & last_d.err);
                if (last_d.vld) dout_q <= last_d.data;
            end
        end

        if (p == 0) begin : g_out_a
            assign ram_dout_a = dout_q;
            assign ram_vld_a  = vld_q;
            assign ram_err_a  = err_q;
        end else begin : g_out_b
            assign ram_dout_b = dout_q;
            assign ram_vld_b  = vld_q;
            assign ram_err_b  = err_q;
        end
    end

endmodule

// File: tb/tb_msp430_ram_dp.sv
// Drives identical traffic into three RAM instances (read latency 1, 2, 3) and
// checks every port cycle by cycle against a latency-aware expectation queue.
module tb_msp430_ram_dp;

    typedef struct {
        int          edge_n;
        logic [15:0] data;
        logic        oor;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        cen_a = 1'b1, cen_b = 1'b1;
    logic [7:0]  addr_a = '0, addr_b = '0;
    logic [1:0]  wen_a = '1, wen_b = '1;
    logic [15:0] din_a = '0, din_b = '0;

    // index k = 2*instance + port, instance d has read latency d+1
    logic [15:0] dout_w [6];
    logic        vld_w  [6];
    logic        err_w  [6];

    exp_t        sb   [6][$];
    logic [15:0] hold [6];
    logic        errm [6];
    int          edge_cnt = 0;
    int          n_tests  = 0;
    int          n_fail   = 0;

    always #5 clk = ~clk;

    msp430_ram_dp #(.RD_LATENCY(1)) u_lat1 (
        .ram_clk(clk), .ram_rst(rst),
        .ram_cen_a(cen_a), .ram_addr_a(addr_a), .ram_wen_a(wen_a), .ram_din_a(din_a),
        .ram_dout_a(dout_w[0]), .ram_vld_a(vld_w[0]), .ram_err_a(err_w[0]),
        .ram_cen_b(cen_b), .ram_addr_b(addr_b), .ram_wen_b(wen_b), .ram_din_b(din_b),
        .ram_dout_b(dout_w[1]), .ram_vld_b(vld_w[1]), .ram_err_b(err_w[1])
    );

    msp430_ram_dp #(.RD_LATENCY(2)) u_lat2 (
        .ram_clk(clk), .ram_rst(rst),
        .ram_cen_a(cen_a), .ram_addr_a(addr_a), .ram_wen_a(wen_a), .ram_din_a(din_a),
        .ram_dout_a(dout_w[2]), .ram_vld_a(vld_w[2]), .ram_err_a(err_w[2]),
        .ram_cen_b(cen_b), .ram_addr_b(addr_b), .ram_wen_b(wen_b), .ram_din_b(din_b),
        .ram_dout_b(dout_w[3]), .ram_vld_b(vld_w[3]), .ram_err_b(err_w[3])
    );

    msp430_ram_dp #(.RD_LATENCY(3)) u_lat3 (
        .ram_clk(clk), .ram_rst(rst),
        .ram_cen_a(cen_a), .ram_addr_a(addr_a), .ram_wen_a(wen_a), .ram_din_a(din_a),
        .ram_dout_a(dout_w[4]), .ram_vld_a(vld_w[4]), .ram_err_a(err_w[4]),
        .ram_cen_b(cen_b), .ram_addr_b(addr_b), .ram_wen_b(wen_b), .ram_din_b(din_b),
        .ram_dout_b(dout_w[5]), .ram_vld_b(vld_w[5]), .ram_err_b(err_w[5])
    );

    function automatic int lat(input int k);
        return k / 2 + 1;
    endfunction

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp_v);
        n_tests++;
        assert (obs === exp_v) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp_v);
        end
    endtask

    task automatic check_outputs();
        for (int k = 0; k < 6; k++) begin
            exp_t e;
            logic due;
            due = (sb[k].size() > 0) && (sb[k][0].edge_n + lat(k) - 1 == edge_cnt);
            if (due) begin
                e       = sb[k].pop_front();
                hold[k] = e.data;
                if (e.oor) errm[k] = 1'b1;
            end
            chk($sformatf("vld[%0d]@%0d", k, edge_cnt), 16'(vld_w[k]), 16'(due));
            chk($sformatf("dout[%0d]@%0d", k, edge_cnt), dout_w[k], hold[k]);
            chk($sformatf("err[%0d]@%0d", k, edge_cnt), 16'(err_w[k]), 16'(errm[k]));
        end
    endtask

    task automatic check_reset();
        for (int k = 0; k < 6; k++) begin
            chk($sformatf("rst_vld[%0d]", k), 16'(vld_w[k]), 16'h0);
            chk($sformatf("rst_dout[%0d]", k), dout_w[k], 16'h0);
            chk($sformatf("rst_err[%0d]", k), 16'(err_w[k]), 16'h0);
        end
    endtask

    // One clock of stimulus: ca/cb select an access; ea/eb are the words the
    // access must return. Address, wen and din are driven even when idle.
    task automatic step(
        input bit ca, input logic [7:0] aa, input logic [1:0] wa, input logic [15:0] da, input logic [15:0] ea,
        input bit cb, input logic [7:0] ab, input logic [1:0] wb, input logic [15:0] db, input logic [15:0] eb
    );
        cen_a = ~ca; addr_a = aa; wen_a = wa; din_a = da;
        cen_b = ~cb; addr_b = ab; wen_b = wb; din_b = db;
        @(posedge clk);
        edge_cnt++;
        for (int d = 0; d < 3; d++) begin
            if (ca) sb[2*d].push_back('{edge_n: edge_cnt, data: ea, oor: (aa >= 8'd128)});
            if (cb) sb[2*d+1].push_back('{edge_n: edge_cnt, data: eb, oor: (ab >= 8'd128)});
        end
        @(negedge clk);
        check_outputs();
    endtask

    task automatic idle();
        step(1'b0, 8'h00, 2'b11, 16'h0000, 16'h0000, 1'b0, 8'h00, 2'b11, 16'h0000, 16'h0000);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        for (int k = 0; k < 6; k++) begin
            hold[k] = '0;
            errm[k] = 1'b0;
        end
        repeat (2) @(negedge clk);
        check_outputs();
        rst = 1'b0;
        idle();

        // byte-lane write and write-first readback on port A
        step(1, 8'd5, 2'b00, 16'h1234, 16'h1234, 0, 8'd0, 2'b11, 16'h0, 16'h0);
        step(1, 8'd5, 2'b01, 16'hAB00, 16'hAB34, 0, 8'd0, 2'b11, 16'h0, 16'h0);
        step(1, 8'd5, 2'b11, 16'h0000, 16'hAB34, 0, 8'd0, 2'b11, 16'h0, 16'h0);
        // disabled port with write-looking inputs must not touch memory
        step(0, 8'd5, 2'b00, 16'hFFFF, 16'h0000, 0, 8'd5, 2'b00, 16'hEEEE, 16'h0);
        step(1, 8'd5, 2'b11, 16'h0000, 16'hAB34, 0, 8'd0, 2'b11, 16'h0, 16'h0);

        // preload then back-to-back reads on port B
        for (int i = 0; i < 4; i++)
            step(1, 8'(i), 2'b00, 16'(i * 16'h1111), 16'(i * 16'h1111), 0, 8'd0, 2'b11, 16'h0, 16'h0);
        for (int i = 0; i < 4; i++)
            step(0, 8'd0, 2'b11, 16'h0, 16'h0, 1, 8'(i), 2'b11, 16'h0, 16'(i * 16'h1111));
        idle();
        idle();

        // same-cycle collisions: overlapping lane, then disjoint lanes
        step(1, 8'd10, 2'b00, 16'hAAAA, 16'hAAAA, 1, 8'd10, 2'b10, 16'hBBBB, 16'hAAAA);
        step(1, 8'd10, 2'b11, 16'h0000, 16'hAAAA, 0, 8'd0, 2'b11, 16'h0, 16'h0);
        step(1, 8'd11, 2'b00, 16'h1122, 16'h1122, 0, 8'd0, 2'b11, 16'h0, 16'h0);
        step(1, 8'd11, 2'b01, 16'h3300, 16'h3344, 1, 8'd11, 2'b10, 16'h0044, 16'h3344);
        step(0, 8'd0, 2'b11, 16'h0, 16'h0, 1, 8'd11, 2'b11, 16'h0, 16'h3344);

        // cross-port read returns the other port's new data
        step(1, 8'd20, 2'b00, 16'h5A5A, 16'h5A5A, 1, 8'd20, 2'b11, 16'h0, 16'h5A5A);
        step(1, 8'd21, 2'b11, 16'h0000, 16'h7777, 1, 8'd21, 2'b00, 16'h7777, 16'h7777);

        // out-of-range: zero data, sticky error, no aliasing write
        step(1, 8'd72, 2'b00, 16'h0F0F, 16'h0F0F, 0, 8'd0, 2'b11, 16'h0, 16'h0);
        step(1, 8'd200, 2'b11, 16'h0000, 16'h0000, 0, 8'd0, 2'b11, 16'h0, 16'h0);
        step(1, 8'd200, 2'b00, 16'hDEAD, 16'h0000, 0, 8'd0, 2'b11, 16'h0, 16'h0);
        step(1, 8'd72, 2'b11, 16'h0000, 16'h0F0F, 0, 8'd0, 2'b11, 16'h0, 16'h0);
        step(1, 8'd0, 2'b11, 16'h0000, 16'h0000, 1, 8'd20, 2'b11, 16'h0, 16'h5A5A);
        repeat (3) idle();

        // asynchronous reset one cycle after a read discards in-flight data
        step(1, 8'd5, 2'b11, 16'h0000, 16'hAB34, 0, 8'd0, 2'b11, 16'h0, 16'h0);
        #2 rst = 1'b1;
        #1 check_reset();
        for (int k = 0; k < 6; k++) begin
            sb[k].delete();
            hold[k] = '0;
            errm[k] = 1'b0;
        end
        idle();
        rst = 1'b0;
        repeat (4) idle();
        step(1, 8'd5, 2'b11, 16'h0000, 16'hAB34, 1, 8'd3, 2'b11, 16'h0, 16'h3333);
        repeat (4) idle();

        for (int k = 0; k < 6; k++)
            chk($sformatf("drain[%0d]", k), 16'(sb[k].size()), 16'h0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
